// File: rtl/alucalcm.sv
// LCM stage: latches a, b and their GCD g, forms a*b with a shift-add multiplier,
// then divides by g with a restoring divider and reports the 2*WIDTH-bit quotient.
module alucalcm #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     g,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(2 * WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]       rem_shift_s;
    logic                 rem_ge_s;

    // The remainder never exceeds g-1, so shifting in the next dividend bit fits in WIDTH+1 bits.
    assign rem_shift_s = {rem_q[WIDTH-1:0], acc_q[2*WIDTH-1]};
    assign rem_ge_s    = (rem_shift_s >= {1'b0, div_q});

    // Next-state and datapath update for the handshake, multiply and divide phases.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        div_d    = div_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        result_d = result_q;
        done_d   = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    div_d    = g;
                    acc_d    = '0;
                    rem_d    = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    if (g == '0) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = S_DONE;
                    end else if ((a == '0) || (b == '0)) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_MULT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = S_DIV;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                if (rem_ge_s) begin
                    rem_d = rem_shift_s - {1'b0, div_q};
                end else begin
                    rem_d = rem_shift_s;
                end
                acc_d = {acc_q[2*WIDTH-2:0], rem_ge_s};
                if (cnt_q == CW'(2 * WIDTH - 1)) begin
                    result_d = {acc_q[2*WIDTH-2:0], rem_ge_s};
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            div_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            div_q    <= div_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_alucalcm.sv
// Self-checking bench for alucalcm: directed cases, randomized operands and a
// GCD-chained sweep, all checked against arithmetic reference results.
module tb_alucalcm;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  g;
    logic        done;
    logic        busy;
    logic        err;
    logic [15:0] result;

    int n_checks;
    int n_fail;

    alucalcm #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .g      (g),
        .done   (done),
        .busy   (busy),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gcd_ref(input int x, input int y);
        int p;
        int q;
        int t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Smallest positive multiple of x that y divides.
    function automatic int lcm_ref(input int x, input int y);
        int m;
        m = x;
        while ((m % y) != 0) m = m + x;
        return m;
    endfunction

    // One request: accept, optionally pulse a stray start, then check latency, busy span and outputs.
    task automatic run_case(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic [7:0] tg, input logic [15:0] exp_res, input logic exp_err,
                            input int exp_lat, input int inject);
        int  k;
        int  busy_cnt;
        bit  seen;
        a = ta;
        b = tb_v;
        g = tg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        g = 8'($urandom);
        busy_cnt = 0;
        seen = 1'b0;
        k = 0;
        while (k < 100) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (k == inject);
            if (k == inject) begin
                a = 8'd3;
                b = 8'd5;
                g = 8'd1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d edges", name, k);
        end else begin
            n_checks++;
            if (k !== exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected %0d", name, k, exp_lat);
            end
            n_checks++;
            if (busy_cnt !== exp_lat) begin
                n_fail++;
                $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat);
            end
            n_checks++;
            if (result !== exp_res) begin
                n_fail++;
                $display("FAIL %s result: got %0d expected %0d", name, result, exp_res);
            end
            n_checks++;
            if (err !== exp_err) begin
                n_fail++;
                $display("FAIL %s err: got %0b expected %0b", name, err, exp_err);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ((done !== 1'b0) || (result !== exp_res)) begin
                n_fail++;
                $display("FAIL %s after_done: done=%0b result=%0d expected done=0 result=%0d",
                         name, done, result, exp_res);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        g = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({done, busy, err, result} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_values: done=%0b busy=%0b err=%0b result=%0d expected all 0",
                     done, busy, err, result);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ((busy !== 1'b0) || (done !== 1'b0)) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%0b done=%0b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        run_case("lcm_4_6",     8'd4,   8'd6,   8'd2,  16'd12,    1'b0, 25, -1);
        run_case("lcm_255_254", 8'd255, 8'd254, 8'd1,  16'hFD02,  1'b0, 25, -1);
        run_case("lcm_15_15",   8'd15,  8'd15,  8'd15, 16'd15,    1'b0, 25, -1);
        run_case("lcm_1_1",     8'd1,   8'd1,   8'd1,  16'd1,     1'b0, 25, -1);
        run_case("zero_a",      8'd0,   8'd9,   8'd9,  16'd0,     1'b0, 1,  -1);
        run_case("g_zero",      8'd7,   8'd7,   8'd0,  16'd0,     1'b1, 1,  -1);
        run_case("zero_b",      8'd9,   8'd0,   8'd9,  16'd0,     1'b0, 1,  -1);
        run_case("g_nondiv",    8'd10,  8'd7,   8'd3,  16'd23,    1'b0, 25, -1);
    endtask

    task automatic test_ignored_start();
        run_case("ignore_start", 8'd4, 8'd6, 8'd2, 16'd12, 1'b0, 25, 5);
    endtask

    task automatic test_back_to_back();
        int k;
        int pulses;
        a = 8'd5;
        b = 8'd3;
        g = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd7;
        b = 8'd6;
        g = 8'd1;
        pulses = 0;
        k = 0;
        while (k < 200) begin
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    n_checks++;
                    if ((k !== 25) || (result !== 16'd15) || (busy !== 1'b0)) begin
                        n_fail++;
                        $display("FAIL b2b_first: edge=%0d result=%0d busy=%0b expected 25 15 0",
                                 k, result, busy);
                    end
                end else begin
                    n_checks++;
                    if ((k !== 51) || (result !== 16'd42)) begin
                        n_fail++;
                        $display("FAIL b2b_second: edge=%0d result=%0d expected 51 42", k, result);
                    end
                    start = 1'b0;
                    break;
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done pulses expected 2", pulses);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release: busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        run_case("pre_abort", 8'd4, 8'd6, 8'd2, 16'd12, 1'b0, 25, -1);
        a = 8'd200;
        b = 8'd100;
        g = 8'd50;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({done, busy, err, result} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_abort: done=%0b busy=%0b err=%0b result=%0d expected all 0",
                     done, busy, err, result);
        end
        #20;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_case("post_abort", 8'd12, 8'd18, 8'd6, 16'd36, 1'b0, 25, -1);
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rg;
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ((i % 3) == 0) rg = 8'($urandom_range(0, 3));
            else if ((i % 3) == 1) rg = 8'($urandom);
            else rg = 8'(gcd_ref(int'(ra), int'(rb)));
            if (rg == 8'd0)
                run_case("random", ra, rb, rg, 16'd0, 1'b1, 1, -1);
            else if ((ra == 8'd0) || (rb == 8'd0))
                run_case("random", ra, rb, rg, 16'd0, 1'b0, 1, -1);
            else
                run_case("random", ra, rb, rg, 16'((int'(ra) * int'(rb)) / int'(rg)), 1'b0, 25, -1);
        end
    endtask

    task automatic test_gcd_chain();
        for (int i = 1; i <= 15; i++) begin
            for (int j = 1; j <= 15; j++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                run_case("chain", 8'(i), 8'(j), 8'(gcd_ref(i, j)), 16'(lcm_ref(i, j)), 1'b0, 25, -1);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_gcd_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
